// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants for the DSP post-adder datapath
package dsp_pkg;
  localparam int DSP_WIDTH = 48;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [DSP_WIDTH-1:0] SAT_MAX = {1'b0, {(DSP_WIDTH-1){1'b1}}};
  localparam logic [DSP_WIDTH-1:0] SAT_MIN = {1'b1, {(DSP_WIDTH-1){1'b0}}};
endpackage

// File: rtl/dsp_post_adder_if.sv
// rtl/dsp_post_adder_if.sv - operand/result bundle of the post-adder (sat_flag with DSP_POST_ADDER_SAT_EN)
interface dsp_post_adder_if #(
  parameter int WIDTH = dsp_pkg::DSP_WIDTH
);
  logic             ce;
  logic             clr_p;
  logic             in_valid;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] z_in;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] p_out;
  logic             carry_out;
  logic             out_valid;
`ifdef DSP_POST_ADDER_SAT_EN
  logic             sat_flag;
`endif

  modport master (
    output ce, clr_p, in_valid, x_in, z_in, cin, sub,
`ifdef DSP_POST_ADDER_SAT_EN
    input  sat_flag,
`endif
    input  p_out, carry_out, out_valid
  );

  modport slave (
    input  ce, clr_p, in_valid, x_in, z_in, cin, sub,
`ifdef DSP_POST_ADDER_SAT_EN
    output sat_flag,
`endif
    output p_out, carry_out, out_valid
  );
endinterface

// File: rtl/dsp_addsub_core.sv
// rtl/dsp_addsub_core.sv - combinational WIDTH+1-bit add/sub with carry and signed overflow
module dsp_addsub_core #(
  parameter int WIDTH = dsp_pkg::DSP_WIDTH
) (
  input  logic [WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             ovf_neg_o
);
  import dsp_pkg::*;

  logic [WIDTH:0]   inner;
  logic [WIDTH:0]   full;
  logic [WIDTH+1:0] xs;
  logic [WIDTH+1:0] zs;
  logic [WIDTH+1:0] exact;

  always_comb begin
    // x+cin kept at WIDTH+1 bits so an all-ones x with cin is not truncated before negation
    inner = {1'b0, x_i} + {{WIDTH{1'b0}}, cin_i};
    if (sub_i == OP_SUB) begin
      full = {1'b0, z_i} + ~inner + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      full = {1'b0, z_i} + inner;
    end

    // exact signed result; overflow when the top three bits disagree
    xs = {{2{x_i[WIDTH-1]}}, x_i} + {{(WIDTH+1){1'b0}}, cin_i};
    zs = {{2{z_i[WIDTH-1]}}, z_i};
    exact = (sub_i == OP_SUB) ? (zs - xs) : (zs + xs);

    sum_o     = full[WIDTH-1:0];
    carry_o   = full[WIDTH];
    ovf_o     = !((exact[WIDTH+1] == exact[WIDTH]) && (exact[WIDTH] == exact[WIDTH-1]));
    ovf_neg_o = exact[WIDTH+1];
  end
endmodule

// File: rtl/dsp_post_adder.sv
// rtl/dsp_post_adder.sv - two-stage Z +/- (X+CIN) post-adder; DSP_POST_ADDER_SAT_EN enables signed saturation
module dsp_post_adder #(
  parameter int WIDTH       = dsp_pkg::DSP_WIDTH,
  parameter bit CARRYOUTREG = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  dsp_post_adder_if.slave bus
);
  logic [WIDTH-1:0] s1_x_q, s1_z_q;
  logic             s1_cin_q, s1_sub_q, s1_v_q;
  logic [WIDTH-1:0] p_q, p_d;
  logic             c_q, c_d, v_q, v_d;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry, core_ovf, core_ovf_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x_q   <= '0;
      s1_z_q   <= '0;
      s1_cin_q <= 1'b0;
      s1_sub_q <= 1'b0;
      s1_v_q   <= 1'b0;
    end else if (bus.ce) begin
      s1_x_q   <= bus.x_in;
      s1_z_q   <= bus.z_in;
      s1_cin_q <= bus.cin;
      s1_sub_q <= bus.sub;
      s1_v_q   <= bus.in_valid;
    end
  end

  dsp_addsub_core #(.WIDTH(WIDTH)) u_core (
    .z_i       (s1_z_q),
    .x_i       (s1_x_q),
    .cin_i     (s1_cin_q),
    .sub_i     (s1_sub_q),
    .sum_o     (core_sum),
    .carry_o   (core_carry),
    .ovf_o     (core_ovf),
    .ovf_neg_o (core_ovf_neg)
  );

`ifdef DSP_POST_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  logic sat_q, sat_d;
  assign bus.sat_flag = sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = core_ovf ^ core_ovf_neg;
`endif

  // clr_p overrides both ce and a coinciding update
  always_comb begin
    p_d = p_q;
    c_d = c_q;
    v_d = v_q;
`ifdef DSP_POST_ADDER_SAT_EN
    sat_d = sat_q;
`endif
    if (bus.clr_p) begin
      p_d = '0;
      c_d = 1'b0;
      v_d = 1'b0;
`ifdef DSP_POST_ADDER_SAT_EN
      sat_d = 1'b0;
`endif
    end else if (bus.ce) begin
      p_d = core_sum;
      c_d = core_carry;
      v_d = s1_v_q;
`ifdef DSP_POST_ADDER_SAT_EN
      sat_d = core_ovf;
      if (core_ovf) p_d = core_ovf_neg ? SAT_MIN_W : SAT_MAX_W;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
`ifdef DSP_POST_ADDER_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      p_q   <= p_d;
      c_q   <= c_d;
      v_q   <= v_d;
`ifdef DSP_POST_ADDER_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign bus.p_out     = p_q;
  assign bus.out_valid = v_q;

  if (CARRYOUTREG) begin : g_carry_reg
    assign bus.carry_out = c_q;
  end else begin : g_carry_comb
    logic unused_c_q;
    assign unused_c_q    = c_q;
    assign bus.carry_out = core_carry;
  end
endmodule

// File: tb/tb_dsp_post_adder.sv
// tb/tb_dsp_post_adder.sv - vector table, random model comparison and corner sequences for dsp_post_adder
module tb_dsp_post_adder;
  import dsp_pkg::*;

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MSB  = 48'h8000_0000_0000;
  localparam logic [47:0] MAXP = 48'h7FFF_FFFF_FFFF;

  typedef struct {
    logic [47:0] x;
    logic [47:0] z;
    logic        cin;
    logic        sub;
    logic [47:0] exp_p;
    logic        exp_c;
    logic [47:0] exp_ps;
    logic        exp_sat;
  } vec_t;

  typedef struct {
    logic [47:0] x;
    logic [47:0] z;
    logic        cin;
    logic        sub;
    logic        v;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  dsp_post_adder_if #(.WIDTH(48)) bus ();

  dsp_post_adder #(.WIDTH(48), .CARRYOUTREG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [47:0] x, input logic [47:0] z, input logic cin, input logic sub, input logic v);
    bus.x_in = x; bus.z_in = z; bus.cin = cin; bus.sub = sub; bus.in_valid = v;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 6))
      0: return '0;
      1: return ONES;
      2: return MSB;
      3: return MAXP;
      4: return 48'($urandom_range(0, 20));
      default: return t[47:0];
    endcase
  endfunction

  // unsigned WIDTH+1 result straight from the arithmetic definition
  function automatic logic [48:0] raw_of(input op_t o);
    logic [48:0] zz, xx;
    zz = {1'b0, o.z};
    xx = {1'b0, o.x} + 49'(o.cin);
    return o.sub ? (zz - xx) : (zz + xx);
  endfunction

`ifdef DSP_POST_ADDER_SAT_EN
  function automatic longint sval_of(input op_t o);
    longint zs, xs;
    zs = $signed(o.z);
    xs = $signed(o.x);
    return o.sub ? (zs - (xs + longint'(o.cin))) : (zs + xs + longint'(o.cin));
  endfunction
`endif

  function automatic logic [47:0] vec_p(input vec_t v);
`ifdef DSP_POST_ADDER_SAT_EN
    return v.exp_ps;
`else
    return v.exp_p;
`endif
  endfunction

  vec_t        vecs[9];
  op_t         m_s1, cur;
  logic [47:0] m_p;
  logic        m_c, m_v;
  logic [48:0] r;
  logic [47:0] last_p;
`ifdef DSP_POST_ADDER_SAT_EN
  logic        m_sat;
  longint      sv;
`endif

  initial begin
    vecs[0] = '{48'd5,  48'd10, 1'b1, 1'b0, 48'd16,          1'b0, 48'd16, 1'b0};
    vecs[1] = '{48'd3,  48'd2,  1'b0, 1'b1, ONES,            1'b1, ONES,   1'b0};
    vecs[2] = '{MSB,    MSB,    1'b0, 1'b0, 48'd0,           1'b1, SAT_MIN, 1'b1};
    vecs[3] = '{48'd3,  48'd10, 1'b1, 1'b1, 48'd6,           1'b0, 48'd6,  1'b0};
    vecs[4] = '{48'd0,  48'd5,  1'b0, 1'b1, 48'd5,           1'b0, 48'd5,  1'b0};
    vecs[5] = '{48'd0,  ONES,   1'b1, 1'b0, 48'd0,           1'b1, 48'd0,  1'b0};
    vecs[6] = '{ONES,   48'd0,  1'b1, 1'b1, 48'd0,           1'b1, 48'd0,  1'b0};
    vecs[7] = '{MAXP,   MAXP,   1'b0, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b0, SAT_MAX, 1'b1};
    vecs[8] = '{48'd1,  MSB,    1'b0, 1'b1, MAXP,            1'b0, SAT_MIN, 1'b1};

    bus.ce = 1'b0; bus.clr_p = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("reset_p", 64'(bus.p_out), 64'd0);
    chk("reset_c", 64'(bus.carry_out), 64'd0);
    chk("reset_v", 64'(bus.out_valid), 64'd0);
`ifdef DSP_POST_ADDER_SAT_EN
    chk("reset_sat", 64'(bus.sat_flag), 64'd0);
`endif
    rst_n = 1'b1;

    // random traffic against the reference model, starting from the reset state
    m_s1 = '{'0, '0, 1'b0, 1'b0, 1'b0};
    m_p = '0; m_c = 1'b0; m_v = 1'b0;
`ifdef DSP_POST_ADDER_SAT_EN
    m_sat = 1'b0;
`endif
    for (int i = 0; i < 400; i++) begin
      cur = '{rnd48(), rnd48(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      bus.ce    = ($urandom_range(0, 3) != 0);
      bus.clr_p = ($urandom_range(0, 19) == 0);
      drive(cur.x, cur.z, cur.cin, cur.sub, cur.v);
      if (bus.clr_p) begin
        m_p = '0; m_c = 1'b0; m_v = 1'b0;
`ifdef DSP_POST_ADDER_SAT_EN
        m_sat = 1'b0;
`endif
      end else if (bus.ce) begin
        r = raw_of(m_s1);
        m_p = r[47:0]; m_c = r[48]; m_v = m_s1.v;
`ifdef DSP_POST_ADDER_SAT_EN
        sv = sval_of(m_s1);
        m_sat = (sv > 64'sd140737488355327) || (sv < -64'sd140737488355328);
        if (sv > 64'sd140737488355327) m_p = MAXP;
        else if (sv < -64'sd140737488355328) m_p = MSB;
`endif
      end
      if (bus.ce) m_s1 = cur;
      step();
      chk($sformatf("rand_p[%0d]", i), 64'(bus.p_out), 64'(m_p));
      chk($sformatf("rand_c[%0d]", i), 64'(bus.carry_out), 64'(m_c));
      chk($sformatf("rand_v[%0d]", i), 64'(bus.out_valid), 64'(m_v));
`ifdef DSP_POST_ADDER_SAT_EN
      chk($sformatf("rand_sat[%0d]", i), 64'(bus.sat_flag), 64'(m_sat));
`endif
    end

    // directed vector table: one pulse, result after two edges, valid for one cycle
    bus.ce = 1'b1; bus.clr_p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].x, vecs[i].z, vecs[i].cin, vecs[i].sub, 1'b1);
      step();
      bus.in_valid = 1'b0;
      step();
      chk($sformatf("vec_p[%0d]", i), 64'(bus.p_out), 64'(vec_p(vecs[i])));
      chk($sformatf("vec_c[%0d]", i), 64'(bus.carry_out), 64'(vecs[i].exp_c));
      chk($sformatf("vec_v[%0d]", i), 64'(bus.out_valid), 64'd1);
`ifdef DSP_POST_ADDER_SAT_EN
      chk($sformatf("vec_sat[%0d]", i), 64'(bus.sat_flag), 64'(vecs[i].exp_sat));
`endif
      step();
      chk($sformatf("vec_vdrop[%0d]", i), 64'(bus.out_valid), 64'd0);
    end
    last_p = vec_p(vecs[8]);

    // ce stall between operand and result
    drive(48'd7, 48'd1, 1'b0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0; bus.ce = 1'b0;
    bus.x_in = 48'd100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_p[%0d]", k), 64'(bus.p_out), 64'(last_p));
      chk($sformatf("stall_v[%0d]", k), 64'(bus.out_valid), 64'd0);
    end
    bus.ce = 1'b1;
    step();
    chk("stall_res_p", 64'(bus.p_out), 64'd8);
    chk("stall_res_v", 64'(bus.out_valid), 64'd1);

    // clr_p beats a result arriving on the same edge, then the pipe continues
    drive(48'd20, 48'd22, 1'b0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0; bus.clr_p = 1'b1;
    step();
    chk("clr_p", 64'(bus.p_out), 64'd0);
    chk("clr_c", 64'(bus.carry_out), 64'd0);
    chk("clr_v", 64'(bus.out_valid), 64'd0);
    bus.clr_p = 1'b0;
    drive(48'd1, 48'd2, 1'b0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("post_clr_p", 64'(bus.p_out), 64'd3);
    chk("post_clr_v", 64'(bus.out_valid), 64'd1);
    bus.ce = 1'b0; bus.clr_p = 1'b1;
    step();
    chk("clr_noce_p", 64'(bus.p_out), 64'd0);
    chk("clr_noce_v", 64'(bus.out_valid), 64'd0);
    bus.clr_p = 1'b0; bus.ce = 1'b1;

    // asynchronous reset with operands in flight
    drive(48'd9, 48'd9, 1'b1, 1'b0, 1'b1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p", 64'(bus.p_out), 64'd0);
    chk("arst_c", 64'(bus.carry_out), 64'd0);
    chk("arst_v", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("arst_no_v[%0d]", k), 64'(bus.out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
